// File: rtl/sd_clk_gen.sv
// rtl/sd_clk_gen.sv - SD clock divider: decodes CSD TRAN_SPEED, serially divides, drives sd_clk.
// Define CLKDIV_ROUND_UP_EN to round the period count up so sd_clk never exceeds the decoded rate.
module sd_clk_gen #(
    parameter logic [31:0] SYS_CLK_HZ = 32'd50_000_000,
    parameter int          COUNT_W    = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [7:0]         tran_speed,
    input  logic               init_mode,
    input  logic               sd_clk_en,
    output logic               busy,
    output logic               ok,
    output logic               err,
    output logic [COUNT_W-1:0] count,
    output logic               sd_clk
);

    typedef enum logic [1:0] {IDLE, DECODE, DIV, DONE} state_t;

    localparam logic [COUNT_W-1:0] ONE         = COUNT_W'(1);
    localparam logic [COUNT_W-1:0] RESET_COUNT = COUNT_W'(SYS_CLK_HZ / 32'd400_000);
    localparam logic [COUNT_W:0]   RESET_SUM   = {1'b0, RESET_COUNT} + (COUNT_W+1)'(1);
    localparam logic [COUNT_W-1:0] RESET_H     = (RESET_SUM[COUNT_W:1] == '0) ? ONE : RESET_SUM[COUNT_W:1];
    localparam logic [32:0]        N_MAX       = (33'd1 << COUNT_W) - 33'd1;

    state_t             state_q, state_d;
    logic [7:0]         ts_q, ts_d;
    logic               im_q, im_d;
    logic [31:0]        div_q, div_d;
    logic [31:0]        quo_q, quo_d;
    logic [31:0]        rem_q, rem_d;
    logic [4:0]         bit_q, bit_d;
    logic               ok_q, ok_d;
    logic               err_q, err_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               sd_clk_q, sd_clk_d;
    logic [COUNT_W-1:0] half_q, half_d;
    logic [COUNT_W-1:0] h_q, h_d;

    logic [31:0]        mult_w, unit_w, rate;
    logic               dec_err;
    logic [32:0]        rem_sh;
    logic               ge;
    logic [31:0]        rem_nx, quo_nx;
    logic [32:0]        n;
    logic               ovf;
    logic [COUNT_W:0]   h_sum;
    logic [COUNT_W-1:0] h_new;

    // Rate decode from the latched CSD byte
    always_comb begin
        mult_w = 32'd0;
        case (ts_q[6:3])
            4'h1: mult_w = 32'd10;
            4'h2: mult_w = 32'd12;
            4'h3: mult_w = 32'd13;
            4'h4: mult_w = 32'd15;
            4'h5: mult_w = 32'd20;
            4'h6: mult_w = 32'd25;
            4'h7: mult_w = 32'd30;
            4'h8: mult_w = 32'd35;
            4'h9: mult_w = 32'd40;
            4'hA: mult_w = 32'd45;
            4'hB: mult_w = 32'd50;
            4'hC: mult_w = 32'd55;
            4'hD: mult_w = 32'd60;
            4'hE: mult_w = 32'd70;
            4'hF: mult_w = 32'd80;
            default: mult_w = 32'd0;
        endcase
        unit_w = 32'd0;
        case (ts_q[2:0])
            3'd0: unit_w = 32'd10_000;
            3'd1: unit_w = 32'd100_000;
            3'd2: unit_w = 32'd1_000_000;
            3'd3: unit_w = 32'd10_000_000;
            default: unit_w = 32'd0;
        endcase
        dec_err = !im_q && (ts_q[7] || (ts_q[2:0] > 3'd3) || (ts_q[6:3] == 4'h0));
        rate    = im_q ? 32'd400_000 : mult_w * unit_w;
    end

    // One restoring-division step; the dividend shifts out of quo_q as quotient bits shift in
    always_comb begin
        rem_sh = {rem_q, quo_q[31]};
        ge     = rem_sh >= {1'b0, div_q};
        rem_nx = ge ? 32'(rem_sh - {1'b0, div_q}) : rem_sh[31:0];
        quo_nx = {quo_q[30:0], ge};
`ifdef CLKDIV_ROUND_UP_EN
        n = {1'b0, quo_nx} + {32'd0, (rem_nx != 32'd0)};
`else
        n = {1'b0, quo_nx};
`endif
        if (n == 33'd0) begin
            n = 33'd1;
        end
        ovf = n > N_MAX;
    end

    always_comb begin
        state_d = state_q;
        ts_d    = ts_q;
        im_d    = im_q;
        div_d   = div_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        bit_d   = bit_q;
        ok_d    = 1'b0;
        err_d   = 1'b0;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    ts_d    = tran_speed;
                    im_d    = init_mode;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                if (dec_err) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    div_d   = rate;
                    quo_d   = SYS_CLK_HZ;
                    rem_d   = 32'd0;
                    bit_d   = 5'd0;
                    state_d = DIV;
                end
            end
            DIV: begin
                quo_d = quo_nx;
                rem_d = rem_nx;
                bit_d = bit_q + 5'd1;
                if (bit_q == 5'd31) begin
                    state_d = DONE;
                    if (ovf) begin
                        err_d = 1'b1;
                    end else begin
                        ok_d    = 1'b1;
                        count_d = n[COUNT_W-1:0];
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A new half period is only picked up at a falling edge or while stopped low
    always_comb begin
        h_sum    = {1'b0, count_q} + (COUNT_W+1)'(1);
        h_new    = (h_sum[COUNT_W:1] == '0) ? ONE : h_sum[COUNT_W:1];
        sd_clk_d = sd_clk_q;
        half_d   = half_q;
        h_d      = h_q;
        if (sd_clk_q) begin
            if (half_q == h_q - ONE) begin
                sd_clk_d = 1'b0;
                half_d   = '0;
                h_d      = h_new;
            end else begin
                half_d = half_q + ONE;
            end
        end else if (!sd_clk_en) begin
            half_d = '0;
            h_d    = h_new;
        end else if (half_q == h_q - ONE) begin
            sd_clk_d = 1'b1;
            half_d   = '0;
        end else begin
            half_d = half_q + ONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            ts_q     <= 8'd0;
            im_q     <= 1'b0;
            div_q    <= 32'd0;
            quo_q    <= 32'd0;
            rem_q    <= 32'd0;
            bit_q    <= 5'd0;
            ok_q     <= 1'b0;
            err_q    <= 1'b0;
            count_q  <= RESET_COUNT;
            sd_clk_q <= 1'b0;
            half_q   <= '0;
            h_q      <= RESET_H;
        end else begin
            state_q  <= state_d;
            ts_q     <= ts_d;
            im_q     <= im_d;
            div_q    <= div_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            bit_q    <= bit_d;
            ok_q     <= ok_d;
            err_q    <= err_d;
            count_q  <= count_d;
            sd_clk_q <= sd_clk_d;
            half_q   <= half_d;
            h_q      <= h_d;
        end
    end

    assign busy   = (state_q != IDLE);
    assign ok     = ok_q;
    assign err    = err_q;
    assign count  = count_q;
    assign sd_clk = sd_clk_q;

endmodule

// File: tb/tb_sd_clk_gen.sv
// tb/tb_sd_clk_gen.sv - directed and randomized checks of sd_clk_gen against an arithmetic model.
module tb_sd_clk_gen;

    localparam longint SYS = 50_000_000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  tran_speed = 8'd0;
    logic        init_mode = 1'b0;
    logic        sd_clk_en = 1'b1;
    logic        busy, ok, err, sd_clk;
    logic [15:0] count;
    logic        busy8, ok8, err8, sd_clk8;
    logic [7:0]  count8;

    int n_cmp = 0;
    int n_bad = 0;
    longint exp_count = 125;
    longint exp_count8 = 125;
    int mults[16] = '{0, 10, 12, 13, 15, 20, 25, 30, 35, 40, 45, 50, 55, 60, 70, 80};
    int units[4]  = '{10_000, 100_000, 1_000_000, 10_000_000};

    sd_clk_gen dut (
        .clk(clk), .reset(reset), .start(start), .tran_speed(tran_speed),
        .init_mode(init_mode), .sd_clk_en(sd_clk_en), .busy(busy), .ok(ok),
        .err(err), .count(count), .sd_clk(sd_clk)
    );

    sd_clk_gen #(.COUNT_W(8)) dut8 (
        .clk(clk), .reset(reset), .start(start), .tran_speed(tran_speed),
        .init_mode(init_mode), .sd_clk_en(sd_clk_en), .busy(busy8), .ok(ok8),
        .err(err8), .count(count8), .sd_clk(sd_clk8)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic void model(input logic [7:0] ts, input logic im, input int w,
                                  output bit dec_err, output bit ovf, output longint n);
        longint rate;
        dec_err = 0;
        ovf     = 0;
        n       = 0;
        if (im) begin
            rate = 400_000;
        end else if (ts[7] || ts[2:0] > 3 || ts[6:3] == 0) begin
            dec_err = 1;
            return;
        end else begin
            rate = longint'(mults[ts[6:3]]) * longint'(units[ts[1:0]]);
        end
        n = SYS / rate;
`ifdef CLKDIV_ROUND_UP_EN
        if (SYS % rate != 0) n++;
`endif
        if (n == 0) n = 1;
        ovf = n > ((longint'(1) << w) - 1);
    endfunction

    function automatic longint half_of(input longint c);
        return (c <= 1) ? 1 : (c + 1) / 2;
    endfunction

    task automatic wait_level(input logic lvl, input string tag);
        int k = 0;
        while (sd_clk !== lvl && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check(tag, sd_clk, lvl);
    endtask

    task automatic measure_phases(input string tag, input longint h);
        longint hi = 0;
        longint lo = 0;
        wait_level(1'b1, {tag, "_w1"});
        wait_level(1'b0, {tag, "_w0"});
        wait_level(1'b1, {tag, "_w2"});
        while (sd_clk === 1'b1 && hi < 3000) begin hi++; @(negedge clk); end
        while (sd_clk === 1'b0 && lo < 3000) begin lo++; @(negedge clk); end
        check({tag, "_high"}, hi, h);
        check({tag, "_low"}, lo, h);
    endtask

    task automatic run_cmd(input logic [7:0] ts, input logic im, input bit poke);
        bit de, ov, de8, ov8;
        longint n, n8;
        model(ts, im, 16, de, ov, n);
        model(ts, im, 8, de8, ov8, n8);
        tran_speed = ts;
        init_mode  = im;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        tran_speed = 8'($urandom);
        init_mode  = 1'($urandom);
        check("busy_t1", busy, 1);
        if (de) begin
            @(negedge clk);
            start = poke;
            check("decerr_t2", {busy, ok, err}, 3'b101);
            check("decerr8_t2", {busy8, ok8, err8}, 3'b101);
        end else begin
            for (int k = 2; k <= 33; k++) begin
                @(negedge clk);
                start      = poke && (k == 5);
                tran_speed = 8'($urandom);
                init_mode  = 1'($urandom);
                check("div_busy", {busy, ok, err}, 3'b100);
            end
            @(negedge clk);
            start = 1'b0;
            check("done_t34", {busy, ok, err}, {1'b1, !ov, ov});
            check("done8_t34", {busy8, ok8, err8}, {1'b1, !ov8, ov8});
            if (!ov) exp_count = n;
            if (!ov8) exp_count8 = n8;
        end
        check("count", count, exp_count);
        check("count8", count8, exp_count8);
        @(negedge clk);
        start = 1'b0;
        check("idle", {busy, ok, err}, 3'b000);
        check("idle8", {busy8, ok8, err8}, 3'b000);
        if (poke) begin
            repeat (3) begin
                @(negedge clk);
                check("no_queue", busy, 0);
            end
        end
    endtask

    initial begin
        longint hi, lo;
        bit stuck, spur;
        logic [7:0] ts;

        repeat (3) @(negedge clk);
        check("rst_flags", {busy, ok, err, sd_clk}, 4'b0000);
        check("rst_count", count, 125);
        check("rst_flags8", {busy8, ok8, err8, sd_clk8}, 4'b0000);
        check("rst_count8", count8, 125);
        reset = 1'b1;
        measure_phases("rst_period", 63);

        // Drop the enable part way through a high phase
        wait_level(1'b0, "en_w0");
        wait_level(1'b1, "en_w1");
        hi = 0;
        repeat (10) begin hi++; @(negedge clk); end
        sd_clk_en = 1'b0;
        while (sd_clk === 1'b1 && hi < 3000) begin hi++; @(negedge clk); end
        check("en_high_full", hi, 63);
        stuck = 0;
        repeat (150) begin
            @(negedge clk);
            if (sd_clk !== 1'b0) stuck = 1;
        end
        check("en_held_low", stuck, 0);
        sd_clk_en = 1'b1;
        lo = 0;
        while (sd_clk === 1'b0 && lo < 3000) begin lo++; @(negedge clk); end
        check("en_full_low", lo, 63);

        run_cmd(8'h00, 1'b1, 1'b0);
        run_cmd(8'h08, 1'b0, 1'b0);
        measure_phases("p100k", half_of(exp_count));
        run_cmd(8'h32, 1'b0, 1'b0);
        check("c25m", count, 2);
        measure_phases("p25m", 1);
        run_cmd(8'h2A, 1'b0, 1'b0);
        measure_phases("p20m", half_of(exp_count));
        run_cmd(8'h00, 1'b0, 1'b1);
        run_cmd(8'h36, 1'b0, 1'b1);

        // Reset ten cycles into a computation
        @(negedge clk);
        tran_speed = 8'h32;
        init_mode  = 1'b0;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b0;
        #1;
        check("mid_rst_flags", {busy, ok, err, sd_clk}, 4'b0000);
        check("mid_rst_count", count, 125);
        exp_count  = 125;
        exp_count8 = 125;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        spur = 0;
        repeat (40) begin
            @(negedge clk);
            if (busy !== 1'b0 || ok !== 1'b0 || err !== 1'b0) spur = 1;
        end
        check("mid_rst_quiet", spur, 0);
        check("mid_rst_count_after", count, 125);
        measure_phases("mid_rst_period", 63);

        for (int i = 0; i < 12; i++) begin
            if ($urandom_range(0, 3) == 0) ts = 8'($urandom);
            else ts = {1'b0, 4'($urandom_range(1, 15)), 3'($urandom_range(0, 3))};
            run_cmd(ts, ($urandom_range(0, 4) == 0), 1'($urandom));
            measure_phases("rand_period", half_of(exp_count));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
